mem_port_arbiter: RTL and testbench

//   Shares the single slow main-memory port between the I-cache (read-only) and
//   the D-cache (read/write) of the pipelined CPU. Requests are granted

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the I-cache, D-cache and main-memory signals of the memory port
//   arbiter. The clock and reset stay outside the bundle.
//   slave  : the arbiter's view. It drives the read data, ready pulses,
//            memory command and wait counters.
//   master : the view of the caches and memory. They drive the requests,
//            the addresses, the write data and the memory response.
//   Signals:
//     i_read, i_addr, i_rdata, i_ready            I-cache read channel
//     d_read, d_write, d_addr, d_wdata,
//     d_rdata, d_ready                            D-cache read/write channel
//     mem_read, mem_write, mem_addr, mem_wdata,
//     mem_rdata, mem_ready                        main-memory port
//     i_wait_cnt, d_wait_cnt                      saturating wait-cycle counters
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CNT_W  = 16
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [CNT_W-1:0]  i_wait_cnt;
   logic [CNT_W-1:0]  d_wait_cnt;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata,
             i_wait_cnt, d_wait_cnt
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata,
             i_wait_cnt, d_wait_cnt
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slow main-memory port between the I-cache (read only) and the
//   D-cache (read/write). Grants are round-robin. A granted transaction holds
//   the registered memory command until mem_ready, and then one IDLE cycle
//   follows so that the served cache can drop its request. Saturating
//   per-requester wait counters record the stall cycles.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active-high
//     bus  mem_port_arbiter_if.slave: cache requests and responses, the
//          memory command and response, and the wait counters
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;     // 1: the D-cache held the most recent grant
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
   logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
   logic              i_req, d_req;
   logic              i_ready, d_ready;
   logic              grant_i, grant_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b1;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_cnt_q     <= '0;
         d_cnt_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_cnt_q     <= i_cnt_d;
         d_cnt_q     <= d_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_cnt_d     = i_cnt_q;
      d_cnt_d     = d_cnt_q;

      i_req   = bus.i_read;
      d_req   = bus.d_read | bus.d_write;
      i_ready = (state_q == GNT_I) & bus.mem_ready;
      d_ready = (state_q == GNT_D) & bus.mem_ready;

      // When both caches request, the one that was not served last wins.
      grant_i = i_req & (~d_req | last_d_q);
      grant_d = d_req & (~i_req | ~last_d_q);

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d     = GNT_I;
               last_d_d    = 1'b0;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = bus.i_addr;
            end else if (grant_d) begin
               state_d     = GNT_D;
               last_d_d    = 1'b1;
               mem_read_d  = ~bus.d_write;
               mem_write_d = bus.d_write;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
            end
         end
         GNT_I, GNT_D: begin
            if (bus.mem_ready) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase

      if (i_req && !i_ready && !(&i_cnt_q)) i_cnt_d = i_cnt_q + CNT_W'(1);
      if (d_req && !d_ready && !(&d_cnt_q)) d_cnt_d = d_cnt_q + CNT_W'(1);
   end

   assign bus.i_rdata    = bus.mem_rdata;
   assign bus.d_rdata    = bus.mem_rdata;
   assign bus.i_ready    = i_ready;
   assign bus.d_ready    = d_ready;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.i_wait_cnt = i_cnt_q;
   assign bus.d_wait_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A transaction-level reference
//   model predicts the memory command, the ready pulses and the wait counters
//   cycle by cycle, while randomised caches and a variable-latency memory
//   drive the design. A second instance with 4-bit counters covers
//   saturation.
module tb_mem_port_arbiter;
   localparam int unsigned AW   = 28;
   localparam int unsigned DW   = 128;
   localparam int unsigned CW   = 16;
   localparam int unsigned CMAX = (1 << CW) - 1;

   typedef struct {
      int              who;     // 1 = I-cache, 2 = D-cache
      int              start;
      logic            wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) sbus ();
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) sdut (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // reference model
   int              m_owner;
   int              m_last;
   logic            m_rd, m_wr;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   int unsigned     m_icnt, m_dcnt;

   // stimulus control
   bit   i_auto, d_auto, hold, i_drop, d_drop, lat_rand, prev_cmd, saw_ir, saw_dr;
   int   mem_lat, mem_age, noise, cyc;
   txn_t log_q[$];

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   function automatic logic [DW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_owner = 0; m_last = 2; m_rd = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_icnt = 0; m_dcnt = 0;
      prev_cmd = 1'b0; mem_age = 0; i_drop = 1'b0; d_drop = 1'b0;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic tick();
      logic exp_ir, exp_dr, i_req, d_req;
      int   who;
      txn_t t;
      check_eq("mem_read",   bus.mem_read,   m_rd);
      check_eq("mem_write",  bus.mem_write,  m_wr);
      check_eq("mem_addr",   bus.mem_addr,   m_addr);
      check_eq("mem_wdata",  bus.mem_wdata,  m_wdata);
      check_eq("i_wait_cnt", bus.i_wait_cnt, m_icnt);
      check_eq("d_wait_cnt", bus.d_wait_cnt, m_dcnt);
      if ((bus.mem_read || bus.mem_write) && !prev_cmd) begin
         t.who   = (bus.mem_read && bus.mem_addr == bus.i_addr && bus.i_read) ? 1 : 2;
         t.start = cyc;
         t.wr    = bus.mem_write;
         t.addr  = bus.mem_addr;
         t.wdata = bus.mem_wdata;
         log_q.push_back(t);
         if (lat_rand) mem_lat = $urandom_range(0, 5);
      end
      prev_cmd = bus.mem_read | bus.mem_write;

      if (i_drop) begin
         bus.i_read = 1'b0; i_drop = 1'b0;
      end else if (!bus.i_read && i_auto && $urandom_range(0, 2) == 0) begin
         bus.i_read = 1'b1; bus.i_addr = AW'($urandom);
      end
      if (d_drop) begin
         bus.d_read = 1'b0; bus.d_write = 1'b0; d_drop = 1'b0;
      end else if (!bus.d_read && !bus.d_write && d_auto && $urandom_range(0, 2) == 0) begin
         who = int'($urandom_range(0, 2));
         bus.d_read  = (who != 1);
         bus.d_write = (who != 0);
         bus.d_addr  = AW'($urandom);
         bus.d_wdata = rnd_line();
      end

      if (bus.mem_read || bus.mem_write) begin
         bus.mem_ready = (mem_age >= mem_lat);
         mem_age++;
      end else begin
         mem_age = 0;
         bus.mem_ready = (noise == 2) || (noise == 1 && $urandom_range(0, 3) == 0);
      end
      bus.mem_rdata = rnd_line();
      #1;

      exp_ir = bus.mem_ready && (m_owner == 1);
      exp_dr = bus.mem_ready && (m_owner == 2);
      check_eq("i_ready", bus.i_ready, exp_ir);
      check_eq("d_ready", bus.d_ready, exp_dr);
      if (exp_ir) check_eq("i_rdata", bus.i_rdata, bus.mem_rdata);
      if (exp_dr) check_eq("d_rdata", bus.d_rdata, bus.mem_rdata);
      if (bus.i_ready) begin saw_ir = 1'b1; if (!hold) i_drop = 1'b1; end
      if (bus.d_ready) begin saw_dr = 1'b1; if (!hold) d_drop = 1'b1; end

      i_req = bus.i_read;
      d_req = bus.d_read | bus.d_write;
      if (i_req && !exp_ir && m_icnt < CMAX) m_icnt++;
      if (d_req && !exp_dr && m_dcnt < CMAX) m_dcnt++;
      if (m_owner != 0) begin
         if (bus.mem_ready) begin m_owner = 0; m_rd = 1'b0; m_wr = 1'b0; end
      end else if (i_req || d_req) begin
         if (i_req && d_req) who = (m_last == 1) ? 2 : 1;
         else who = i_req ? 1 : 2;
         m_owner = who; m_last = who;
         if (who == 1) begin
            m_rd = 1'b1; m_wr = 1'b0; m_addr = bus.i_addr;
         end else begin
            m_wr = bus.d_write; m_rd = !bus.d_write;
            m_addr = bus.d_addr; m_wdata = bus.d_wdata;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      model_reset();
      log_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      bus.i_read = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
      sbus.i_read = 1'b0; sbus.i_addr = '0; sbus.d_read = 1'b0; sbus.d_write = 1'b0;
      sbus.d_addr = '0; sbus.d_wdata = '0; sbus.mem_rdata = '0; sbus.mem_ready = 1'b0;
      i_auto = 1'b0; d_auto = 1'b0; hold = 1'b0; lat_rand = 1'b0;
      saw_ir = 1'b0; saw_dr = 1'b0; mem_lat = 4; noise = 0; cyc = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state, stray mem_ready in IDLE must not produce ready pulses
      check_eq("rst_mem_read",  bus.mem_read,  0);
      check_eq("rst_mem_write", bus.mem_write, 0);
      noise = 1;
      repeat (10) tick();
      check_eq("rst_no_ready", {saw_ir, saw_dr}, 0);

      // single I read, 4 cycles of memory latency
      noise = 0; mem_lat = 4;
      bus.i_addr = 28'h0000010; bus.i_read = 1'b1;
      c0 = cyc; saw_ir = 1'b0;
      for (int unsigned k = 0; k < 20 && !saw_ir; k++) tick();
      check_eq("t2_ready_seen", saw_ir, 1);
      tick();
      check_eq("t2_wait_cnt", bus.i_wait_cnt, 5);
      check_eq("t2_ntxn", log_q.size(), 1);
      if (log_q.size() >= 1) begin
         check_eq("t2_addr", log_q[0].addr, 28'h0000010);
         check_eq("t2_start", log_q[0].start, c0 + 1);
      end

      // simultaneous I read and D write from reset: I first, one idle cycle, D
      do_reset();
      mem_lat = 2;
      bus.i_addr = 28'h0000123; bus.i_read = 1'b1;
      bus.d_addr = 28'h0ABCDEF; bus.d_wdata = rnd_line(); bus.d_write = 1'b1;
      saw_ir = 1'b0; saw_dr = 1'b0;
      for (int unsigned k = 0; k < 30 && !(saw_ir && saw_dr); k++) tick();
      check_eq("t3_both_served", {saw_ir, saw_dr}, 2'b11);
      tick();
      check_eq("t3_ntxn", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         check_eq("t3_first_who", log_q[0].who, 1);
         check_eq("t3_second_who", log_q[1].who, 2);
         check_eq("t3_second_wr", log_q[1].wr, 1);
         check_eq("t3_second_wdata", log_q[1].wdata, bus.d_wdata);
         check_eq("t3_spacing", log_q[1].start - log_q[0].start, 4);
      end

      // fairness with both requests held throughout
      do_reset();
      mem_lat = 1; hold = 1'b1;
      bus.i_addr = 28'h0000040; bus.i_read = 1'b1;
      bus.d_addr = 28'h0000080; bus.d_read = 1'b1;
      for (int unsigned k = 0; k < 80 && log_q.size() < 6; k++) tick();
      check_eq("t4_ntxn", log_q.size() >= 6, 1);
      for (int unsigned k = 0; k < 6 && k < log_q.size(); k++)
         check_eq($sformatf("t4_grant%0d", k), log_q[k].who, (k % 2) + 1);
      hold = 1'b0;
      bus.i_read = 1'b0; bus.d_read = 1'b0;
      repeat (8) tick();

      // reset in the middle of a D write, late mem_ready afterwards
      do_reset();
      mem_lat = 20;
      bus.d_addr = 28'h0FEED00; bus.d_wdata = rnd_line(); bus.d_write = 1'b1;
      for (int unsigned k = 0; k < 10 && !bus.mem_write; k++) tick();
      check_eq("t5_granted", bus.mem_write, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_async_write", bus.mem_write, 0);
      check_eq("t5_async_addr", bus.mem_addr, 0);
      check_eq("t5_async_wdata", bus.mem_wdata, 0);
      check_eq("t5_async_dcnt", bus.d_wait_cnt, 0);
      bus.d_write = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      noise = 2; saw_dr = 1'b0;
      repeat (6) tick();
      check_eq("t5_no_dready", saw_dr, 0);
      noise = 0;

      // saturation on the 4-bit counter instance, memory never answers
      sbus.d_read = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("t6_cnt10", sbus.d_wait_cnt, 10);
      check_eq("t6_granted", sbus.mem_read, 1);
      repeat (5) @(negedge clk);
      check_eq("t6_cnt15", sbus.d_wait_cnt, 15);
      repeat (10) @(negedge clk);
      check_eq("t6_sat", sbus.d_wait_cnt, 4'hF);
      sbus.d_read = 1'b0;

      // randomised traffic against the model
      do_reset();
      i_auto = 1'b1; d_auto = 1'b1; lat_rand = 1'b1; noise = 1;
      repeat (500) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
